// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: func3 codes, FSM state codes and
// the byte-lane extract/extend/merge helpers used by dmem_ctrl.
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    function automatic logic illegal_func3(input logic we, input logic [2:0] func3);
        if (we)
            return func3 > F3_SW;
        return (func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7);
    endfunction

    // Only meaningful for legal func3; bits [1:0] encode the access size for loads and stores.
    function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] lane);
        return ((func3[1:0] == 2'd1) && lane[0]) || ((func3[1:0] == 2'd2) && (lane != 2'd0));
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] func3,
                                                input logic [1:0] lane);
        logic [31:0]        byte_sh;
        logic [31:0]        half_sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        byte_sh = word >> {lane, 3'b000};
        half_sh = word >> {lane[1], 4'b0000};
        b = byte_sh[7:0];
        h = half_sh[15:0];
        case (func3)
            F3_LB:   return 32'(b);
            F3_LBU:  return {24'd0, byte_sh[7:0]};
            F3_LH:   return 32'(h);
            F3_LHU:  return {16'd0, half_sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                                input logic [2:0] func3, input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] ins;
        case (func3)
            F3_SB: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                ins  = {24'd0, wdata[7:0]} << {lane, 3'b000};
            end
            F3_SH: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                ins  = {16'd0, wdata[15:0]} << {lane[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                ins  = wdata;
            end
        endcase
        return (old_word & ~mask) | (ins & mask);
    endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// Single-port word-wide RAM: synchronous write, registered synchronous read.
module dmem_word_ram
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic                      re,
    input  logic [MEM_WORDS_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);

    logic [DATA_WIDTH-1:0] mem [2**MEM_WORDS_LOG2];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: one load/store at a time, sub-word stores via read-modify-write.
// Optional macro DMEM_MISALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_WIDTH      = 31,
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_func3,
    input  logic [RAM_WIDTH-1:0]  req_address,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    logic [1:0]                state;
    logic                      accept;
    logic                      req_err;
    logic                      req_sw;
    logic [MEM_WORDS_LOG2-1:0] req_index;

    logic                      we_p0;
    logic [2:0]                func3_p0;
    logic [1:0]                lane_p0;
    logic [MEM_WORDS_LOG2-1:0] index_p0;
    logic [DATA_WIDTH-1:0]     wdata_p0;

    logic                      ram_we;
    logic                      ram_re;
    logic [MEM_WORDS_LOG2-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]     ram_wdata;
    logic [DATA_WIDTH-1:0]     ram_rdata;

    // Address bits above the RAM depth alias onto the same words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_address[RAM_WIDTH-1:MEM_WORDS_LOG2+2];

    assign req_index = req_address[MEM_WORDS_LOG2+1:2];
    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_sw    = req_we && (req_func3 == F3_SW);

    always_comb begin
        req_err = illegal_func3(req_we, req_func3);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (misaligned(req_func3, req_address[1:0]))
            req_err = 1'b1;
`endif
    end

    // Single RAM port: full-word stores in IDLE, read in RD, sub-word merge write in DATA.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = index_p0;
        ram_wdata = store_merge(ram_rdata, wdata_p0, func3_p0, lane_p0);
        case (state)
            ST_IDLE: begin
                ram_addr  = req_index;
                ram_wdata = req_wdata;
                ram_we    = accept && !req_err && req_sw;
            end
            ST_RD:   ram_re = 1'b1;
            ST_DATA: ram_we = we_p0;
            default: ram_we = 1'b0;
        endcase
    end

    dmem_word_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .MEM_WORDS_LOG2(MEM_WORDS_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // Stage p0: request fields captured at acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            func3_p0 <= req_func3;
            lane_p0  <= req_address[1:0];
            index_p0 <= req_index;
            wdata_p0 <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_sw) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD:   state <= ST_DATA;
                ST_DATA: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    if (!we_p0)
                        resp_rdata <= load_extend(ram_rdata, func3_p0, lane_p0);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized traffic against a word-array model.
module tb_dmem_ctrl;

    localparam int MW = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [30:0] req_address = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    dmem_ctrl #(.DATA_WIDTH(32), .RAM_WIDTH(31), .MEM_WORDS_LOG2(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_func3  (req_func3),
        .req_address(req_address),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour derived from the access rules, operating on whole words.
    task automatic model(input logic we, input logic [2:0] f3, input logic [30:0] addr,
                         input logic [31:0] wd, output logic e, output int lat,
                         output logic [31:0] rd);
        int          idx;
        int          boff;
        int          hoff;
        logic [31:0] w;
        longint      v;
        idx  = int'((addr / 4) % (1 << MW));
        boff = int'(addr % 4);
        hoff = (boff >= 2) ? 2 : 0;
        e = we ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7);
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((f3 % 4 == 1 && addr % 2 != 0) || (f3 % 4 == 2 && addr % 4 != 0))
            e = 1'b1;
`endif
        rd  = 32'd0;
        lat = (e || (we && f3 == 2)) ? 1 : 3;
        if (e)
            return;
        w = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
        if (we) begin
            if (f3 == 2)
                w = wd;
            else if (f3 == 0)
                w = (w & ~(32'hFF << (8 * boff))) | ((wd % 256) << (8 * boff));
            else
                w = (w & ~(32'hFFFF << (8 * hoff))) | ((wd % 65536) << (8 * hoff));
            ref_mem[idx] = w;
        end else begin
            case (f3)
                3'd0, 3'd4: begin
                    v = (w >> (8 * boff)) % 256;
                    if (f3 == 0 && v >= 128)
                        v = v - 256;
                end
                3'd1, 3'd5: begin
                    v = (w >> (8 * hoff)) % 65536;
                    if (f3 == 1 && v >= 32768)
                        v = v - 65536;
                end
                default: v = w;
            endcase
            rd = 32'(v);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [30:0] addr,
                          input logic [31:0] wd, input string tag, output logic [31:0] got);
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rd;
        int          pulses;
        int          seen_lat;
        logic [31:0] seen_rd;
        logic        seen_err;
        model(we, f3, addr, wd, exp_err, exp_lat, exp_rd);
        @(negedge clk);
        check_eq({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_we      = we;
        req_func3   = f3;
        req_address = addr;
        req_wdata   = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        pulses   = 0;
        seen_lat = 0;
        seen_rd  = 32'd0;
        seen_err = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                pulses++;
                seen_lat = k;
                seen_rd  = resp_rdata;
                seen_err = resp_err;
            end
        end
        check_eq({tag, ".pulses"}, 32'(pulses), 32'd1);
        check_eq({tag, ".latency"}, 32'(seen_lat), 32'(exp_lat));
        check_eq({tag, ".err"}, 32'(seen_err), 32'(exp_err));
        check_eq({tag, ".rdata"}, seen_rd, exp_rd);
        got = seen_rd;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] wd;
        logic [30:0] addr;
        logic [2:0]  f3;
        logic        we;

        repeat (3) @(negedge clk);
        check_eq("reset.ready", 32'(req_ready), 32'd0);
        check_eq("reset.valid", 32'(resp_valid), 32'd0);
        check_eq("reset.rdata", resp_rdata, 32'd0);
        check_eq("reset.err", 32'(resp_err), 32'd0);
        rst = 1'b0;

        do_req(1'b1, 3'd2, 31'h10, 32'hDEADBEEF, "sw10", got);
        do_req(1'b0, 3'd2, 31'h10, 32'd0, "lw10", got);
        check_eq("lw10.const", got, 32'hDEADBEEF);
        do_req(1'b1, 3'd0, 31'h11, 32'h000000AA, "sb11", got);
        do_req(1'b0, 3'd0, 31'h11, 32'd0, "lb11", got);
        check_eq("lb11.const", got, 32'hFFFFFFAA);
        do_req(1'b0, 3'd4, 31'h11, 32'd0, "lbu11", got);
        check_eq("lbu11.const", got, 32'h000000AA);
        do_req(1'b0, 3'd2, 31'h10, 32'd0, "lw10b", got);
        check_eq("lw10b.const", got, 32'hDEADAAEF);
        do_req(1'b1, 3'd1, 31'h12, 32'h00008001, "sh12", got);
        do_req(1'b0, 3'd1, 31'h12, 32'd0, "lh12", got);
        check_eq("lh12.const", got, 32'hFFFF8001);
        do_req(1'b0, 3'd5, 31'h12, 32'd0, "lhu12", got);
        check_eq("lhu12.const", got, 32'h00008001);
        do_req(1'b0, 3'd2, 31'h13, 32'd0, "lw13", got);
`ifdef DMEM_MISALIGN_CHECK_EN
        check_eq("lw13.const", got, 32'h0);
`else
        check_eq("lw13.const", got, 32'h8001AAEF);
`endif
        do_req(1'b0, 3'd3, 31'h10, 32'd0, "ld_f3_3", got);
        do_req(1'b1, 3'd5, 31'h10, 32'h1234, "st_f3_5", got);
        do_req(1'b0, 3'd2, 31'h1010, 32'd0, "lw_alias", got);
        check_eq("lw_alias.const", got, 32'h8001AAEF);

        for (int i = 0; i < 32; i++)
            do_req(1'b1, 3'd2, 31'(i * 4), $urandom, "fill", got);

        for (int i = 0; i < 200; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 31'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0)
                addr = addr | (31'($urandom_range(1, 255)) << 12);
            wd = $urandom;
            do_req(we, f3, addr, wd, "rand", got);
        end

        do_req(1'b1, 3'd2, 31'h20, 32'h12345678, "sw20", got);
        @(negedge clk);
        check_eq("abort.ready", 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_we      = 1'b1;
        req_func3   = 3'd0;
        req_address = 31'h20;
        req_wdata   = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check_eq("abort.c1_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort.rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq("abort.rst_valid", 32'(resp_valid), 32'd0);
        check_eq("abort.rst_rdata", resp_rdata, 32'd0);
        check_eq("abort.rst_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("abort.release_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("abort.post_valid", 32'(resp_valid), 32'd0);
        end
        do_req(1'b0, 3'd2, 31'h20, 32'd0, "lw20", got);
        check_eq("lw20.const", got, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
